// File: rtl/outer_ram_loader.sv
// outer_ram_loader: host-side front end for the outer operand RAM port A.
// Assembles Data/Word narrow host words (LS word first) into one operand and
// writes it in a single cycle. Optional readback path, enabled by defining
// OUTER_RAM_READBACK_EN, reads an operand back and streams it out word-wise.
// Without the macro, rd_start is ignored and m_valid/m_data are tied to 0.
module outer_ram_loader #(
  parameter int Data = 256,
  parameter int Addr = 5,
  parameter int Word = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_start,
  input  logic [Addr:0]     wr_addr,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [Word-1:0]   s_data,
  input  logic              rd_start,
  input  logic [Addr:0]     rd_addr,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [Word-1:0]   m_data,
  output logic              busy,
  output logic              done,
  output logic              a_w,
  output logic [Addr:0]     a_adbus,
  output logic [Data-1:0]   a_data_in,
  input  logic [Data-1:0]   a_data_out
);

  localparam int N  = Data / Word;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_WRITE   = 3'd2
`ifdef OUTER_RAM_READBACK_EN
    ,
    S_RD_ADDR = 3'd3,
    S_RD_WAIT = 3'd4,
    S_UNLOAD  = 3'd5
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic [Addr:0]     addr_q, addr_d;
  logic [Data-1:0]   asm_q, asm_d;
  logic              s_ready_q, s_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              a_w_q, a_w_d;
  logic [Addr:0]     a_adbus_q, a_adbus_d;
`ifdef OUTER_RAM_READBACK_EN
  logic [Data-1:0]   shift_q, shift_d;
  logic [Data-1:0]   shifted_s;
  logic              m_valid_q, m_valid_d;
  logic [Word-1:0]   m_data_q, m_data_d;
`endif

`ifdef OUTER_RAM_READBACK_EN
  // Readback operand advanced by one word; its low word is the next m_data.
  always_comb begin
    shifted_s = shift_q >> Word;
  end
`endif

  // Next-state and next-output logic; every output is computed from the
  // next state so the registered copy is valid in the cycle it applies to.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    addr_d    = addr_q;
    asm_d     = asm_q;
    a_adbus_d = a_adbus_q;
    a_w_d     = 1'b0;
    done_d    = 1'b0;
`ifdef OUTER_RAM_READBACK_EN
    shift_d   = shift_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (wr_start) begin
          // A simultaneous rd_start loses to the write and is dropped.
          state_d = S_LOAD;
          addr_d  = wr_addr;
          k_d     = '0;
          asm_d   = '0;
        end
`ifdef OUTER_RAM_READBACK_EN
        else if (rd_start) begin
          state_d   = S_RD_ADDR;
          a_adbus_d = rd_addr;
          k_d       = '0;
        end
`endif
        else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (s_valid && s_ready_q) begin
          asm_d[k_q*Word +: Word] = s_data;
          k_d = k_q + KW'(1);
          if (k_q == K_LAST) begin
            state_d   = S_WRITE;
            a_w_d     = 1'b1;
            a_adbus_d = addr_q;
            done_d    = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
`ifdef OUTER_RAM_READBACK_EN
      S_RD_ADDR: begin
        // RAM read is registered: data appears in the following cycle.
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        shift_d   = a_data_out;
        m_data_d  = a_data_out[Word-1:0];
        m_valid_d = 1'b1;
        state_d   = S_UNLOAD;
      end
      S_UNLOAD: begin
        if (m_valid_q && m_ready) begin
          shift_d  = shifted_s;
          m_data_d = shifted_s[Word-1:0];
          k_d      = k_q + KW'(1);
          if (k_q == K_LAST) begin
            state_d   = S_IDLE;
            m_valid_d = 1'b0;
            done_d    = 1'b1;
          end else begin
            state_d = S_UNLOAD;
          end
        end else begin
          state_d = S_UNLOAD;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
    s_ready_d = (state_d == S_LOAD);
    busy_d    = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      addr_q    <= '0;
      asm_q     <= '0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      a_w_q     <= 1'b0;
      a_adbus_q <= '0;
`ifdef OUTER_RAM_READBACK_EN
      shift_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      addr_q    <= addr_d;
      asm_q     <= asm_d;
      s_ready_q <= s_ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      a_w_q     <= a_w_d;
      a_adbus_q <= a_adbus_d;
`ifdef OUTER_RAM_READBACK_EN
      shift_q   <= shift_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
`endif
    end
  end

  assign s_ready   = s_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign a_w       = a_w_q;
  assign a_adbus   = a_adbus_q;
  assign a_data_in = asm_q;

`ifdef OUTER_RAM_READBACK_EN
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
`else
  // Readback inputs have no function in this build.
  logic unused_readback_s;
  assign unused_readback_s = ^{rd_start, rd_addr, m_ready, a_data_out};
  assign m_valid = 1'b0;
  assign m_data  = '0;
`endif

endmodule

// File: tb/tb_outer_ram_loader.sv
// Scoreboard bench for outer_ram_loader: stimulus pushes expected RAM writes,
// done pulses and readback words; a negedge monitor pops and compares them.
module tb_outer_ram_loader;

  localparam int DATA = 256;
  localparam int ADDR = 5;
  localparam int WORD = 32;
  localparam int N    = DATA / WORD;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_start, s_valid, s_ready, rd_start, m_valid, m_ready;
  logic              busy, done, a_w;
  logic [ADDR:0]     wr_addr, rd_addr, a_adbus;
  logic [WORD-1:0]   s_data, m_data;
  logic [DATA-1:0]   a_data_in, a_data_out;

  outer_ram_loader #(.Data(DATA), .Addr(ADDR), .Word(WORD)) dut (
    .clk(clk), .rst(rst),
    .wr_start(wr_start), .wr_addr(wr_addr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .rd_start(rd_start), .rd_addr(rd_addr),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .done(done),
    .a_w(a_w), .a_adbus(a_adbus), .a_data_in(a_data_in), .a_data_out(a_data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM port A model with registered read
  logic [DATA-1:0] mem [0:63];
  logic [DATA-1:0] ram_q = '0;
  always @(posedge clk) begin
    if (a_w) mem[a_adbus] <= a_data_in;
    ram_q <= mem[a_adbus];
  end
  assign a_data_out = ram_q;

  typedef struct {
    logic [ADDR:0]   addr;
    logic [DATA-1:0] data;
    int              cyc;
  } wr_exp_t;

  wr_exp_t         wr_q[$];
  int              done_q[$];
  logic [WORD-1:0] rd_q[$];
  int              n_vec = 0;
  int              n_err = 0;
  int              rd_first_cyc = -1;
  bit              rd_seen_first = 1'b1;

  task automatic check(input string name, input logic [DATA-1:0] act, input logic [DATA-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got event at cycle %0d expected none", name, cyc);
  endtask

  // Monitor: compare every DUT-presented event against the scoreboard
  logic            prev_stall = 1'b0;
  logic [WORD-1:0] prev_data = '0;
  wr_exp_t         mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (a_w) begin
        if (wr_q.size() == 0) fail_evt("unexpected_write");
        else begin
          mon_e = wr_q.pop_front();
          check("wr_addr", DATA'(a_adbus), DATA'(mon_e.addr));
          check("wr_data", a_data_in, mon_e.data);
          check_int("wr_cycle", cyc, mon_e.cyc);
        end
      end
      if (done) begin
        if (done_q.size() == 0) fail_evt("unexpected_done");
        else check_int("done_cycle", cyc, done_q.pop_front());
      end
      if (m_valid) begin
        if (prev_stall) check("m_data_hold", DATA'(m_data), DATA'(prev_data));
        if (!rd_seen_first) begin
          rd_seen_first = 1'b1;
          check_int("first_m_valid_cycle", cyc, rd_first_cyc);
        end
        if (m_ready) begin
          if (rd_q.size() == 0) fail_evt("unexpected_read");
          else check("m_data", DATA'(m_data), DATA'(rd_q.pop_front()));
        end
        prev_stall = !m_ready;
        prev_data  = m_data;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_s_ready"},   DATA'(s_ready),   '0);
    check({tag, "_m_valid"},   DATA'(m_valid),   '0);
    check({tag, "_m_data"},    DATA'(m_data),    '0);
    check({tag, "_busy"},      DATA'(busy),      '0);
    check({tag, "_done"},      DATA'(done),      '0);
    check({tag, "_a_w"},       DATA'(a_w),       '0);
    check({tag, "_a_adbus"},   DATA'(a_adbus),   '0);
    check({tag, "_a_data_in"}, a_data_in,        '0);
  endtask

  // Load N words base+step*i to addr; gap idle cycles after word 4;
  // abort_at>=0 asserts rst before that word index; mid pulses a stray wr_start.
  task automatic load(input logic [ADDR:0] addr, input logic [WORD-1:0] base,
                      input logic [WORD-1:0] step, input int gap, input bit both,
                      input bit mid, input int abort_at);
    logic [DATA-1:0] exp;
    logic [WORD-1:0] w;
    int t0;
    bit hs;
    exp = '0;
    for (int i = 0; i < N; i++) exp[i*WORD +: WORD] = base + step * WORD'(i);
    t0 = cyc;
    wr_start = 1'b1; wr_addr = addr;
    rd_start = both; rd_addr = addr;
    if (abort_at < 0) begin
      wr_q.push_back('{addr, exp, t0 + N + 1 + gap});
      done_q.push_back(t0 + N + 1 + gap);
    end
    @(posedge clk); #1;
    wr_start = 1'b0; rd_start = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (abort_at == i) begin
        s_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      if (gap > 0 && i == 4) begin
        s_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
      w = base + step * WORD'(i);
      s_valid = 1'b1; s_data = w;
      if (mid && i == 2) begin wr_start = 1'b1; wr_addr = 6'd20; end
      for (int b = 0; b < 20; b++) begin
        @(negedge clk); hs = s_ready;
        @(posedge clk); #1;
        wr_start = 1'b0;
        if (hs) break;
        if (b == 19) fail_evt("s_ready_timeout");
      end
    end
    s_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
  endtask

`ifdef OUTER_RAM_READBACK_EN
  task automatic readback(input logic [ADDR:0] addr, input logic [WORD-1:0] base,
                          input logic [WORD-1:0] step, input bit toggle);
    int t0;
    t0 = cyc;
    rd_start = 1'b1; rd_addr = addr;
    rd_first_cyc = t0 + 3;
    rd_seen_first = 1'b0;
    for (int i = 0; i < N; i++) rd_q.push_back(base + step * WORD'(i));
    done_q.push_back(toggle ? t0 + 19 : t0 + 11);
    for (int b = 0; b < 40; b++) begin
      @(posedge clk); #1;
      rd_start = 1'b0;
      m_ready = toggle ? ((cyc - t0) % 2 == 0) : 1'b1;
      if (rd_q.size() == 0 && !busy) break;
    end
    m_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    rst = 1'b1;
    wr_start = 1'b0; wr_addr = '0; s_valid = 1'b0; s_data = '0;
    rd_start = 1'b0; rd_addr = '0; m_ready = 1'b1;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // back-to-back load to address 3
    load(6'd3, 32'h1, 32'h1, 0, 1'b0, 1'b0, -1);
    // same load with a 2-cycle bubble after word 4
    load(6'd3, 32'h1, 32'h1, 2, 1'b0, 1'b0, -1);
    // abort after word 5, then a fresh full load to the same address
    load(6'd7, 32'hDEAD0000, 32'h1, 0, 1'b0, 1'b0, 5);
    check_reset_outputs("abort");
    @(posedge clk); #1;
    load(6'd7, 32'h100, 32'h11, 0, 1'b0, 1'b0, -1);
    // wr_start+rd_start together, plus a stray wr_start while busy
    load(6'd12, 32'hC0DE0000, 32'h101, 0, 1'b1, 1'b1, -1);

`ifdef OUTER_RAM_READBACK_EN
    load(6'd10, 32'hA5A5A5A5, 32'h0, 0, 1'b0, 1'b0, -1);
    readback(6'd10, 32'hA5A5A5A5, 32'h0, 1'b1);
    readback(6'd3, 32'h1, 32'h1, 1'b0);
    readback(6'd12, 32'hC0DE0000, 32'h101, 1'b1);
`else
    rd_start = 1'b1; rd_addr = 6'd3;
    @(posedge clk); #1;
    rd_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rd_ignored_busy", DATA'(busy), '0);
      check("rd_ignored_m_valid", DATA'(m_valid), '0);
      @(posedge clk); #1;
    end
`endif

    for (int b = 0; b < 50; b++) begin
      if (wr_q.size() == 0 && done_q.size() == 0 && rd_q.size() == 0) break;
      @(posedge clk); #1;
    end
    while (wr_q.size() != 0) begin void'(wr_q.pop_front()); fail_evt("missing_write"); end
    while (done_q.size() != 0) begin void'(done_q.pop_front()); fail_evt("missing_done"); end
    while (rd_q.size() != 0) begin void'(rd_q.pop_front()); fail_evt("missing_read_word"); end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/outer_ram_loader.md
# outer_ram_loader

Host-side front end for the outer operand RAM: accepts a 256-bit operand as a stream of narrow words, assembles it, and writes it in one cycle through the RAM's external port A (`a_w`, `a_adbus`, `a_data_in`). It sits between the host bus and `Outer_Ram_interface`. It optionally reads an operand back through `a_data_out` and streams it out as narrow words, so results written by the inner module on port B can be collected.

## Interface
- `Data`, 256, operand width; must be an integer multiple of `Word`
- `Addr`, 5, RAM address MSB index; the address bus is `Addr+1` bits
- `Word`, 32, host word width; `N = Data/Word` words per operand (8 at defaults)

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `wr_start`  in  1  one-cycle request to load an operand; honoured only in IDLE
- `wr_addr`  in  Addr+1  target RAM address, sampled with `wr_start`
- `s_valid`  in  1  host word valid
- `s_ready`  out  1  loader accepts a word
- `s_data`  in  Word  host word, least-significant word first
- `rd_start`  in  1  one-cycle readback request; honoured only in IDLE
- `rd_addr`  in  Addr+1  RAM address to read, sampled with `rd_start`
- `m_valid`  out  1  readback word valid
- `m_ready`  in  1  consumer accepts a readback word
- `m_data`  out  Word  readback word, least-significant word first
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when a write or readback completes
- `a_w`  out  1  RAM port A write enable
- `a_adbus`  out  Addr+1  RAM port A address
- `a_data_in`  out  Data  RAM port A write data
- `a_data_out`  in  Data  RAM port A read data; registered read, valid one cycle after the address is presented

## Operation
- States: IDLE, LOAD, WRITE, RD_ADDR, RD_WAIT, UNLOAD.
- IDLE -> LOAD on `wr_start`. The block latches `wr_addr`, clears the word counter, and clears the assembly register.
- LOAD: `s_ready`=1. Each handshake (`s_valid && s_ready`) stores `s_data` into slice `[k*Word +: Word]` and increments k.
  - When the handshake of word N-1 occurs, go to WRITE.
  - `s_valid` while not in LOAD is ignored; words are never dropped while `s_ready` is high.
- WRITE, one cycle:
  - `a_w`=1, `a_adbus`=latched address, `a_data_in`=assembled operand, `done`=1.
  - Next state is IDLE.
- IDLE -> RD_ADDR on `rd_start`:
  - `rd_addr` is latched.
  - RD_ADDR drives `a_adbus` with `a_w`=0.
  - RD_WAIT captures `a_data_out` into the shift register.
  - Next state is UNLOAD.
- UNLOAD: `m_valid`=1, `m_data`=current word. On each `m_ready` handshake, shift right by `Word` and increment k.
  - After handshake N-1, `done`=1 for that cycle and go to IDLE.
- `wr_start` and `rd_start` together in IDLE: the write wins and `rd_start` is dropped.
- Both starts are ignored outside IDLE; `busy` tells the host when it may issue them.
- Word counter is `$clog2(N)` bits wide and wraps to 0 at each operation start. No partial operands are written.
- `a_adbus` holds its last driven value outside WRITE and RD_ADDR. `a_data_in` holds the assembled value.

## Timing
- Reset values: state=IDLE, `s_ready`=0, `m_valid`=0, `m_data`=0, `busy`=0, `done`=0, `a_w`=0, `a_adbus`=0, `a_data_in`=0. The counter and the assembly/shift registers are cleared.
- `rst` mid-operation aborts immediately. No RAM write occurs, and a partially loaded operand is discarded.
- `s_ready` rises the cycle after `wr_start`.
- Write latency: `a_w` is high the cycle after the handshake of word N-1. With back-to-back words, start to `a_w` is N+1 cycles.
- Readback: `rd_start` at cycle 0, RD_ADDR at cycle 1, RD_WAIT at cycle 2, first `m_valid` at cycle 3.
- `m_data` is stable while `m_valid && !m_ready`.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `OUTER_RAM_READBACK_EN` defined: readback path (RD_ADDR, RD_WAIT, UNLOAD, shift register) is compiled in as described above.
- `OUTER_RAM_READBACK_EN` undefined:
  - The readback states and the shift register are removed.
  - `rd_start` is ignored; `m_valid` and `m_data` are tied to 0.
  - `a_data_out` is unused. The ports stay present.

## Test plan
- Reset, then `wr_start` with `wr_addr`=3 and words 0x00000001..0x00000008 back-to-back. Expect one cycle with `a_w`=1, `a_adbus`=3, `a_data_in`=0x00000008_00000007_…_00000001, and `done` pulsing in the same cycle at cycle 9.
- Same load with `s_valid` deasserted for 2 cycles after word 4. Expect the write delayed by 2 cycles, identical data, and `a_w` high for exactly one cycle.
- Assert `rst` after word 5 of a load to address 7. Expect no `a_w` and all outputs at reset values. A subsequent full load to address 7 writes only the new data.
- `wr_start` and `rd_start` in the same cycle. Expect a load to begin and no `m_valid` ever. A `wr_start` issued while `busy`=1 is ignored.
- With the macro defined: preload address 10 with pattern 0xA5A5…, then `rd_start` with `rd_addr`=10 and `m_ready` toggling every cycle. Expect 8 words of 0xA5A5A5A5, first `m_valid` at cycle 3, `m_data` held while stalled, and `done` on the 8th handshake.
- With the macro undefined: pulse `rd_start`. Expect `busy` to stay 0 and `m_valid` to stay 0.
